// File: rtl/sar_adc_control.sv
// sar_adc_control: successive-approximation sequencer driving an R2R DAC code and
// reading back one external comparator. A binary search over WIDTH bits yields the
// code matching the analog input; the final code is left on the DAC afterwards.
module sar_adc_control #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_out,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WIDTH-1:0] MSB_CODE   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    IDX_TOP    = IW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DECIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dac_out;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_cmp_meta;
  logic             r_cmp_s;
  logic [WIDTH-1:0] w_decided;
  logic [WIDTH-1:0] w_next_trial;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp_meta <= 1'b0;
      r_cmp_s    <= 1'b0;
    end else begin
      r_cmp_meta <= cmp;
      r_cmp_s    <= r_cmp_meta;
    end
  end

  // Resolve the current trial bit and form the next trial code (next lower bit set).
  always_comb begin
    w_decided = r_dac_out;
    if (!r_cmp_s) begin
      w_decided[r_idx] = 1'b0;
    end else begin
      w_decided[r_idx] = r_dac_out[r_idx];
    end
    w_next_trial = w_decided;
    if (r_idx != {IW{1'b0}}) begin
      w_next_trial[r_idx - IW'(1)] = 1'b1;
    end else begin
      w_next_trial = w_decided;
    end
  end

  // Conversion FSM: abort wins over start/cont; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dac_out <= {WIDTH{1'b0}};
      r_result  <= {WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= {IW{1'b0}};
      r_cnt     <= {CW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (abort) begin
            r_dac_out <= {WIDTH{1'b0}};
            r_busy    <= 1'b0;
          end else if (start) begin
            r_state   <= S_SETTLE;
            r_dac_out <= MSB_CODE;
            r_idx     <= IDX_TOP;
            r_cnt     <= CNT_RELOAD;
            r_busy    <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_dac_out <= {WIDTH{1'b0}};
            r_busy    <= 1'b0;
          end else if (r_cnt == {CW{1'b0}}) begin
            r_state <= S_DECIDE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DECIDE: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_dac_out <= {WIDTH{1'b0}};
            r_busy    <= 1'b0;
          end else if (r_idx != {IW{1'b0}}) begin
            r_state   <= S_SETTLE;
            r_dac_out <= w_next_trial;
            r_idx     <= r_idx - IW'(1);
            r_cnt     <= CNT_RELOAD;
          end else begin
            r_state   <= S_DONE;
            r_dac_out <= w_decided;
            r_result  <= w_decided;
            r_done    <= 1'b1;
          end
        end
        S_DONE: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_dac_out <= {WIDTH{1'b0}};
            r_busy    <= 1'b0;
          end else if (cont) begin
            r_state   <= S_SETTLE;
            r_dac_out <= MSB_CODE;
            r_idx     <= IDX_TOP;
            r_cnt     <= CNT_RELOAD;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_dac_out <= {WIDTH{1'b0}};
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign dac_out = r_dac_out;
  assign result  = r_result;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_sar_adc_control.sv
// Bench for sar_adc_control: behavioural comparator (vin_code >= dac_out), directed
// conversions; expected results/done cycles are queued at start and checked by a monitor.
module tb_sar_adc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic       cmp;
  logic [7:0] dac_out;
  logic [7:0] result;
  logic       busy;
  logic       done;
  logic [7:0] vin_code = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc = 0;

  typedef struct packed {
    logic [7:0]  code;
    logic [31:0] at;
  } exp_t;
  exp_t exp_q[$];

  sar_adc_control #(.WIDTH(8), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort), .cmp(cmp),
    .dac_out(dac_out), .result(result), .busy(busy), .done(done)
  );

  assign cmp = (vin_code >= dac_out);

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_result", {24'd0, result}, {24'd0, e.code});
        check("done_cycle", cyc, e.at);
      end
    end
  end

  // Leaves us at the negedge where cyc == acc (first SETTLE cycle).
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  logic [7:0] trials [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  logic [7:0] edge_vin [2] = '{8'h00, 8'hFF};

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dac", {24'd0, dac_out}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 0xA5 with trial-code trace
    vin_code = 8'hA5;
    do_start();
    exp_q.push_back('{code: 8'hA5, at: 32'(acc + 40)});
    for (int i = 0; i < 8; i++) begin
      wait_cycle(acc + 5 * i);
      check("trial_code", {24'd0, dac_out}, {24'd0, trials[i]});
      check("busy_conv", {31'd0, busy}, 32'd1);
    end
    wait_cycle(acc + 41);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_dac_holds", {24'd0, dac_out}, 32'h000000A5);

    // 2: full-scale boundaries
    for (int k = 0; k < 2; k++) begin
      vin_code = edge_vin[k];
      do_start();
      exp_q.push_back('{code: edge_vin[k], at: 32'(acc + 40)});
      wait_cycle(acc + 42);
    end

    // 3: start while busy is ignored
    vin_code = 8'h5A;
    do_start();
    exp_q.push_back('{code: 8'h5A, at: 32'(acc + 40)});
    wait_cycle(acc + 5);  start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cycle(acc + 20); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cycle(acc + 60);
    check("no_queued_start", {31'd0, busy}, 32'd0);

    // 4: abort mid-conversion
    vin_code = 8'h33;
    do_start();
    wait_cycle(acc + 12);
    abort = 1'b1;
    wait_cycle(acc + 13);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dac", {24'd0, dac_out}, 32'd0);
    check("abort_result_kept", {24'd0, result}, 32'h0000005A);
    wait_cycle(acc + 60);

    // 5: continuous mode
    vin_code = 8'h3C;
    cont = 1'b1;
    do_start();
    exp_q.push_back('{code: 8'h3C, at: 32'(acc + 40)});
    exp_q.push_back('{code: 8'hC3, at: 32'(acc + 81)});
    wait_cycle(acc + 40);
    vin_code = 8'hC3;
    wait_cycle(acc + 50);
    cont = 1'b0;
    wait_cycle(acc + 82);
    check("cont_idle_busy", {31'd0, busy}, 32'd0);
    check("cont_idle_dac", {24'd0, dac_out}, 32'h000000C3);

    // 6: async reset mid-SETTLE, then a fresh conversion
    vin_code = 8'h77;
    do_start();
    wait_cycle(acc + 7);
    #20 rst = 1'b1;
    #10;
    check("rst_dac", {24'd0, dac_out}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vin_code = 8'h96;
    do_start();
    exp_q.push_back('{code: 8'h96, at: 32'(acc + 40)});
    wait_cycle(acc + 50);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
